match_controller: RTL and testbench
===================================

# match_controller

Frame-tick-driven round/match sequencer for the fighter game; sits between the per-player blocks (`player_move`, `player_attack`) and the top level. It gates `move_enable`/`attack_enable` for both players and runs the round clock. It decides KO/time-out per round, counts round wins and ends the match. It also emits a state/timer bus for the HUD renderer.

## Interface
- `FRAMES_PER_SEC`, 60: `SCEN` pulses per timer second.
- `COUNTDOWN_SEC`, 3: pre-round countdown length in seconds.
- `ROUND_SEC`, 99: round time limit in seconds (≤127).
- `END_HOLD_FRAMES`, 120: frames held in ROUND_END.
- `WINS_TO_MATCH`, 2: round wins needed to take the match (≤3).
- `MAX_ROUNDS`, 5: hard cap on rounds per match (≤7).
- `clk` in 1: pixel clock (25 MHz); sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `SCEN` in 1: one-`clk` frame tick; all sequencing advances only on it.
- `start_btn` in 1: start button, level, already debounced.
- `p1_health` in 7: player 1 health; 0 = KO.
- `p2_health` in 7: player 2 health; 0 = KO.
- `move_enable` out 1: high only in FIGHT.
- `attack_enable` out 1: high only in FIGHT.
- `game_state` out 3: 0 ATTRACT, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER.
- `countdown` out 2: seconds left in COUNTDOWN (3..1); 0 in all other states.
- `round_timer` out 7: seconds left in the round.
- `round_num` out 3: current round, 1-based; 0 in ATTRACT.
- `p1_wins` out 2: player 1 round wins.
- `p2_wins` out 2: player 2 round wins.
- `round_winner` out 2: 0 none, 1 P1, 2 P2, 3 draw.
- `match_winner` out 2: same encoding as `round_winner`.
- `health_reset` out 1: one-`clk` pulse commanding health refill and player respawn.

## Operation
- All registers update only on a `clk` edge where `SCEN`=1; the only exception is `health_reset`.
- `start_btn` is sampled on each `SCEN`. A start event is a sample of 1 when the previous sample was 0.
- Internal `frame_cnt` runs 0..`FRAMES_PER_SEC`-1 and is cleared on every state entry. Internal `hold_cnt` is used in ROUND_END.
- ATTRACT:
  - On a start event: clear wins and winners, set `round_num`=1, go to COUNTDOWN.
- COUNTDOWN:
  - On entry, `countdown`=`COUNTDOWN_SEC` and `round_timer`=`ROUND_SEC`.
  - `countdown` decrements on each `frame_cnt` wrap.
  - The wrap that would take it to 0 goes to FIGHT instead.
- FIGHT:
  - `round_timer` decrements on each `frame_cnt` wrap and saturates at 0.
  - Evaluation order on each tick:
    - Both healths 0: draw.
    - Only `p1_health`=0: P2 wins the round.
    - Only `p2_health`=0: P1 wins the round.
    - `round_timer`=0: the higher health wins; equal health is a draw.
  - Any of these outcomes sets `round_winner`, increments the winner's count (a draw increments neither), and goes to ROUND_END.
- ROUND_END:
  - Hold for `END_HOLD_FRAMES` ticks, then exit by priority:
    - If either win count equals `WINS_TO_MATCH`: set `match_winner` to that player, go to MATCH_OVER.
    - Else if `round_num`=`MAX_ROUNDS`: go to MATCH_OVER; the player with more wins takes the match, equal wins gives a draw (3).
    - Otherwise: increment `round_num`, clear `round_winner`, go to COUNTDOWN.
- MATCH_OVER:
  - A start event behaves exactly as the one in ATTRACT.
- `health_reset`: one-`clk` pulse on the cycle after every entry into COUNTDOWN.
- Start events are ignored in COUNTDOWN, FIGHT and ROUND_END.

## Timing
- Reset values:
  - `game_state`=0, enables 0, `countdown`=0, `round_timer`=`ROUND_SEC`.
  - `round_num`=0, wins 0, winners 0, `health_reset`=0.
  - Start-sample register 0, so a button held through reset is not an event.
- Latency:
  - State and enable changes are visible the cycle after the `SCEN` edge that causes them.
  - `health_reset` follows one cycle later.
- A COUNTDOWN→FIGHT transition and the first `round_timer` decrement are `FRAMES_PER_SEC` ticks apart.
- A KO and the timer reaching 0 on the same tick resolve as a KO.
- Health inputs are ignored outside FIGHT.
- Asserting `reset_n` mid-round returns everything to reset values immediately, with no pulse on `health_reset`.
- Win counters saturate at `WINS_TO_MATCH`.

## Configuration
- `MATCH_TIMER_EN` defined:
  - Round timer counts down.
  - A round can end by time-out as described above.
- `MATCH_TIMER_EN` undefined:
  - `round_timer` is held at `ROUND_SEC` permanently.
  - Time-out never occurs; rounds end only by KO.

## Test plan
- `reset_n` low, then high with `start_btn` held → state stays ATTRACT. Release, then press → COUNTDOWN, `round_num`=1, `health_reset` pulses once.
- Defaults, after start → `countdown` reads 3,2,1 at 60-tick spacing. FIGHT after 180 ticks, `move_enable`=1, `round_timer`=99 then 98 after 60 more ticks.
- In FIGHT, `p2_health`=0 → `round_winner`=1, `p1_wins`=1, enables drop next cycle. 120 ticks later → COUNTDOWN, `round_num`=2.
- P1 KO'd twice → MATCH_OVER, `match_winner`=2. `start_btn` press → new match, wins 0.
- With `MATCH_TIMER_EN`, `FRAMES_PER_SEC`=2, `ROUND_SEC`=3, healths 40/40 held → draw at timer 0, wins unchanged. Without the macro, the same stimulus stays in FIGHT indefinitely.
- Both healths 0 on the same tick → `round_winner`=3. 5 draws → MATCH_OVER with `match_winner`=3.

Source files
------------

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
// match_controller : frame-tick round/match sequencer (countdown, fight, KO /
// time-out judging, win counting, HUD state bus). Optional: MATCH_TIMER_EN.
// Revision: 1.0
// ============================================================================
module match_controller #(
   parameter int FRAMES_PER_SEC  = 60,
   parameter int COUNTDOWN_SEC   = 3,
   parameter int ROUND_SEC       = 99,
   parameter int END_HOLD_FRAMES = 120,
   parameter int WINS_TO_MATCH   = 2,
   parameter int MAX_ROUNDS      = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       SCEN,
   input  logic       start_btn,
   input  logic [6:0] p1_health,
   input  logic [6:0] p2_health,
   output logic       move_enable,
   output logic       attack_enable,
   output logic [2:0] game_state,
   output logic [1:0] countdown,
   output logic [6:0] round_timer,
   output logic [2:0] round_num,
   output logic [1:0] p1_wins,
   output logic [1:0] p2_wins,
   output logic [1:0] round_winner,
   output logic [1:0] match_winner,
   output logic       health_reset
);

   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam int HW = (END_HOLD_FRAMES > 1) ? $clog2(END_HOLD_FRAMES) : 1;
   localparam logic [FW-1:0] C_FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
   localparam logic [HW-1:0] C_HOLD_LAST  = HW'(END_HOLD_FRAMES - 1);
   localparam logic [1:0]    C_CD_INIT    = 2'(COUNTDOWN_SEC);
   localparam logic [6:0]    C_ROUND_INIT = 7'(ROUND_SEC);
   localparam logic [1:0]    C_WINS       = 2'(WINS_TO_MATCH);
   localparam logic [2:0]    C_MAX_ROUNDS = 3'(MAX_ROUNDS);

   typedef enum logic [2:0] {
      S_ATTRACT    = 3'd0,
      S_COUNTDOWN  = 3'd1,
      S_FIGHT      = 3'd2,
      S_ROUND_END  = 3'd3,
      S_MATCH_OVER = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [1:0]      cd_q, cd_d;
   logic [6:0]      timer_q, timer_d;
   logic [2:0]      rnd_q, rnd_d;
   logic [1:0]      w1_q, w1_d;
   logic [1:0]      w2_q, w2_d;
   logic [1:0]      rw_q, rw_d;
   logic [1:0]      mw_q, mw_d;
   // Resets low so a button held through reset must be released before it counts.
   logic            start_low_q, start_low_d;
   logic            cd_entry_q;
   logic            health_reset_q;

   logic            start_ev;
   logic            frame_wrap;
   logic            enter_cd;
   logic [1:0]      outcome;

   assign start_ev   = start_btn & start_low_q;
   assign frame_wrap = (frame_q == C_FRAME_LAST);

   always_comb begin
      outcome = 2'd0;
      if (p1_health == 7'd0 && p2_health == 7'd0) begin
         outcome = 2'd3;
      end else if (p1_health == 7'd0) begin
         outcome = 2'd2;
      end else if (p2_health == 7'd0) begin
         outcome = 2'd1;
`ifdef MATCH_TIMER_EN
      end else if (timer_q == 7'd0) begin
         if (p1_health > p2_health)      outcome = 2'd1;
         else if (p2_health > p1_health) outcome = 2'd2;
         else                            outcome = 2'd3;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_wrap ? '0 : frame_q + 1'b1;
      hold_d      = hold_q;
      cd_d        = cd_q;
      timer_d     = timer_q;
      rnd_d       = rnd_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      rw_d        = rw_q;
      mw_d        = mw_q;
      start_low_d = ~start_btn;
      enter_cd    = 1'b0;

      case (state_q)
         S_ATTRACT, S_MATCH_OVER: begin
            if (start_ev) begin
               w1_d     = 2'd0;
               w2_d     = 2'd0;
               rw_d     = 2'd0;
               mw_d     = 2'd0;
               rnd_d    = 3'd1;
               enter_cd = 1'b1;
            end
         end
         S_COUNTDOWN: begin
            if (frame_wrap) begin
               if (cd_q == 2'd1) begin
                  state_d = S_FIGHT;
                  cd_d    = 2'd0;
               end else begin
                  cd_d = cd_q - 2'd1;
               end
            end
         end
         S_FIGHT: begin
            if (outcome != 2'd0) begin
               rw_d    = outcome;
               state_d = S_ROUND_END;
               if (outcome == 2'd1 && w1_q != C_WINS) w1_d = w1_q + 2'd1;
               if (outcome == 2'd2 && w2_q != C_WINS) w2_d = w2_q + 2'd1;
`ifdef MATCH_TIMER_EN
            end else if (frame_wrap && timer_q != 7'd0) begin
               timer_d = timer_q - 7'd1;
`endif
            end
         end
         S_ROUND_END: begin
            hold_d = hold_q + 1'b1;
            if (hold_q == C_HOLD_LAST) begin
               if (w1_q == C_WINS) begin
                  mw_d    = 2'd1;
                  state_d = S_MATCH_OVER;
               end else if (w2_q == C_WINS) begin
                  mw_d    = 2'd2;
                  state_d = S_MATCH_OVER;
               end else if (rnd_q == C_MAX_ROUNDS) begin
                  state_d = S_MATCH_OVER;
                  if (w1_q > w2_q)      mw_d = 2'd1;
                  else if (w2_q > w1_q) mw_d = 2'd2;
                  else                  mw_d = 2'd3;
               end else begin
                  rnd_d    = rnd_q + 3'd1;
                  rw_d     = 2'd0;
                  enter_cd = 1'b1;
               end
            end
         end
         default: state_d = S_ATTRACT;
      endcase

      if (enter_cd) begin
         state_d = S_COUNTDOWN;
         cd_d    = C_CD_INIT;
         timer_d = C_ROUND_INIT;
      end
      if (state_d != state_q) begin
         frame_d = '0;
         hold_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_ATTRACT;
         frame_q        <= '0;
         hold_q         <= '0;
         cd_q           <= 2'd0;
         timer_q        <= C_ROUND_INIT;
         rnd_q          <= 3'd0;
         w1_q           <= 2'd0;
         w2_q           <= 2'd0;
         rw_q           <= 2'd0;
         mw_q           <= 2'd0;
         start_low_q    <= 1'b0;
         cd_entry_q     <= 1'b0;
         health_reset_q <= 1'b0;
      end else begin
         // The refill pulse is the one path that runs every clk, not per frame tick.
         cd_entry_q     <= SCEN & enter_cd;
         health_reset_q <= cd_entry_q;
         if (SCEN) begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            cd_q        <= cd_d;
            timer_q     <= timer_d;
            rnd_q       <= rnd_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            rw_q        <= rw_d;
            mw_q        <= mw_d;
            start_low_q <= start_low_d;
         end
      end
   end

   assign move_enable   = (state_q == S_FIGHT);
   assign attack_enable = (state_q == S_FIGHT);
   assign game_state    = state_q;
   assign countdown     = cd_q;
   assign round_timer   = timer_q;
   assign round_num     = rnd_q;
   assign p1_wins       = w1_q;
   assign p2_wins       = w2_q;
   assign round_winner  = rw_q;
   assign match_winner  = mw_q;
   assign health_reset  = health_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
// tb_match_controller : randomized-tick bench for match_controller, checked
// every cycle against a tick-count reference model.
// Revision: 1.0
// ============================================================================
module tb_match_controller;

   localparam int FPS  = 3;
   localparam int CD   = 3;
   localparam int RS   = 4;
   localparam int HOLD = 4;
   localparam int WINS = 2;
   localparam int MAXR = 5;
`ifdef MATCH_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       scen = 1'b0;
   logic       start_btn = 1'b0;
   logic [6:0] h1 = 7'd50;
   logic [6:0] h2 = 7'd50;
   logic       move_enable, attack_enable, health_reset;
   logic [2:0] game_state, round_num;
   logic [1:0] countdown, p1_wins, p2_wins, round_winner, match_winner;
   logic [6:0] round_timer;

   always #5 clk = ~clk;

   match_controller #(
      .FRAMES_PER_SEC (FPS),
      .COUNTDOWN_SEC  (CD),
      .ROUND_SEC      (RS),
      .END_HOLD_FRAMES(HOLD),
      .WINS_TO_MATCH  (WINS),
      .MAX_ROUNDS     (MAXR)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .SCEN         (scen),
      .start_btn    (start_btn),
      .p1_health    (h1),
      .p2_health    (h2),
      .move_enable  (move_enable),
      .attack_enable(attack_enable),
      .game_state   (game_state),
      .countdown    (countdown),
      .round_timer  (round_timer),
      .round_num    (round_num),
      .p1_wins      (p1_wins),
      .p2_wins      (p2_wins),
      .round_winner (round_winner),
      .match_winner (match_winner),
      .health_reset (health_reset)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase plus ticks elapsed since entering it.
   int m_st, m_tk, m_rnd, m_w1, m_w2, m_rw, m_mw, m_timer;
   int m_last;     // previous start sample; 1 after reset means "not yet seen released"
   int m_edge;     // clk edge counter
   int m_hr_at;    // edge after which the refill pulse is expected

   task automatic model_reset();
      m_st = 0; m_tk = 0; m_rnd = 0; m_w1 = 0; m_w2 = 0;
      m_rw = 0; m_mw = 0; m_timer = RS; m_last = 1; m_hr_at = -1;
   endtask

   task automatic model_start_round();
      m_st = 1; m_tk = 0; m_timer = RS; m_hr_at = m_edge + 1;
   endtask

   task automatic model_tick(input int st_b, input int a, input int b);
      int o;
      bit ev;
      ev = (st_b != 0) && (m_last == 0);
      m_last = st_b;
      case (m_st)
         0, 4: if (ev) begin
            m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0; m_rnd = 1;
            model_start_round();
         end
         1: begin
            m_tk++;
            if (m_tk == CD * FPS) begin m_st = 2; m_tk = 0; end
         end
         2: begin
            o = 0;
            if (a == 0 && b == 0)            o = 3;
            else if (a == 0)                 o = 2;
            else if (b == 0)                 o = 1;
            else if (TIMER_ON && m_timer == 0) o = (a > b) ? 1 : (b > a) ? 2 : 3;
            if (o != 0) begin
               m_rw = o;
               if (o == 1 && m_w1 < WINS) m_w1++;
               if (o == 2 && m_w2 < WINS) m_w2++;
               m_st = 3; m_tk = 0;
            end else begin
               m_tk++;
               if (TIMER_ON) m_timer = (RS - m_tk / FPS > 0) ? RS - m_tk / FPS : 0;
            end
         end
         3: begin
            m_tk++;
            if (m_tk == HOLD) begin
               if (m_w1 == WINS)      begin m_mw = 1; m_st = 4; end
               else if (m_w2 == WINS) begin m_mw = 2; m_st = 4; end
               else if (m_rnd == MAXR) begin
                  m_mw = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3;
                  m_st = 4;
               end else begin
                  m_rnd++; m_rw = 0;
                  model_start_round();
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("game_state",    game_state,    m_st);
      check("move_enable",   move_enable,   (m_st == 2) ? 1 : 0);
      check("attack_enable", attack_enable, (m_st == 2) ? 1 : 0);
      check("countdown",     countdown,     (m_st == 1) ? CD - m_tk / FPS : 0);
      check("round_timer",   round_timer,   m_timer);
      check("round_num",     round_num,     m_rnd);
      check("p1_wins",       p1_wins,       m_w1);
      check("p2_wins",       p2_wins,       m_w2);
      check("round_winner",  round_winner,  m_rw);
      check("match_winner",  match_winner,  m_mw);
      check("health_reset",  health_reset,  (m_edge == m_hr_at) ? 1 : 0);
   endtask

   // One clk cycle; inputs change only at the falling edge.
   task automatic step();
      scen = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      m_edge++;
      if (reset_n && scen) model_tick(int'(start_btn), int'(h1), int'(h2));
      @(negedge clk);
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_st(input int s, input int budget, input string tag);
      int k;
      k = 0;
      while (m_st != s && k < budget) begin
         step();
         k++;
      end
      check(tag, game_state, s);
   endtask

   task automatic async_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      run(2);
      reset_n = 1'b1;
   endtask

   task automatic press_start(input string tag);
      start_btn = 1'b0;
      run(3);
      start_btn = 1'b1;
      wait_st(1, 30, tag);
      start_btn = 1'b0;
   endtask

   initial begin
      m_edge = 0;
      model_reset();
      start_btn = 1'b1;
      #2;
      async_reset();

      // Button held through reset: no start event.
      run(15);
      check("held_start_ignored", game_state, 0);

      press_start("start_to_countdown");
      check("first_round_num", round_num, 1);
      wait_st(2, 200, "countdown_to_fight");

      run(4);
      h2 = 7'd0;
      wait_st(3, 20, "p2_ko");
      check("p1_wins_after_ko", p1_wins, 1);
      h2 = 7'd50;
      wait_st(1, 100, "next_round");
      check("second_round_num", round_num, 2);

      for (int i = 0; i < 2; i++) begin
         wait_st(2, 200, "fight_for_p1_ko");
         run(2);
         h1 = 7'd0;
         wait_st(3, 20, "p1_ko");
         h1 = 7'd50;
      end
      wait_st(4, 100, "match_over_p2");
      check("match_winner_p2", match_winner, 2);

      press_start("restart_after_match");
      check("restart_p2_wins", p2_wins, 0);

      // Five double-KO draws run the match out to the round cap.
      for (int i = 0; i < MAXR; i++) begin
         wait_st(2, 200, "fight_for_draw");
         run(1);
         h1 = 7'd0;
         h2 = 7'd0;
         wait_st(3, 20, "double_ko");
         check("double_ko_winner", round_winner, 3);
         h1 = 7'd50;
         h2 = 7'd50;
      end
      wait_st(4, 100, "match_over_draw");
      check("match_winner_draw", match_winner, 3);

      // Equal health held: time-out draw only when the round timer is built in.
      h1 = 7'd40;
      h2 = 7'd40;
      press_start("restart_timeout");
      wait_st(2, 200, "fight_for_timeout");
      begin
         int k;
         k = 0;
         while (m_st == 2 && k < 80) begin
            step();
            k++;
         end
      end
      check("timeout_state",  game_state,   TIMER_ON ? 3 : 2);
      check("timeout_winner", round_winner, TIMER_ON ? 3 : 0);
      check("timeout_p1wins", p1_wins, 0);

      // Reset mid-round, then reset while a refill pulse is pending.
      h1 = 7'd60;
      h2 = 7'd30;
      wait_st(2, 200, "fight_before_reset");
      run(3);
      async_reset();
      check("reset_mid_round_state", game_state, 0);
      press_start("start_before_reset");
      async_reset();
      run(3);
      check("no_pulse_after_reset", health_reset, 0);

      // Randomized play.
      h1 = 7'd50;
      h2 = 7'd50;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) start_btn = ~start_btn;
         if ($urandom_range(0, 29) == 0)
            h1 = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         if ($urandom_range(0, 29) == 0)
            h2 = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
